// File: rtl/sp_inst_fetch.sv
// rtl/sp_inst_fetch.sv - program memory and one-at-a-time instruction issue stage for the SP core
// Define SP_IF_WATCHDOG_EN to build the WAIT-state timeout (fault code 01).
module sp_inst_fetch #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned INST_LIMIT  = 1000,
  parameter int unsigned MAX_LATENCY = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic                     start,
  input  logic                     out_valid,
  input  logic [31:0]              inst_addr,
  output logic                     in_valid,
  output logic [31:0]              inst,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               fault,
  output logic [15:0]              issued_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || MAX_LATENCY < 1) begin : g_param_check
    $error("sp_inst_fetch: DEPTH must be >= 2 and MAX_LATENCY >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        in_valid_q, in_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] mem [DEPTH];

  logic ctrl_open;
  logic addr_bad;
  logic wd_expired;

  assign ctrl_open = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAULT);
  assign addr_bad  = (inst_addr[1:0] != 2'b00) || ((inst_addr >> 2) >= DEPTH);

`ifdef SP_IF_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;

  assign wd_expired = (wd_q == 16'(MAX_LATENCY - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_q == S_ISSUE) begin
      wd_d = '0;
    end else if (state_q == S_WAIT && !out_valid) begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    in_valid_d = 1'b0;
    inst_d     = '0;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          fault_d = 2'b00;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Memory is read here, one edge after start, so a same-cycle load is visible.
        in_valid_d = 1'b1;
        inst_d     = mem[pc_q[AW+1:2]];
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (out_valid) begin
          pc_d = inst_addr;
          if (cnt_q == 16'(INST_LIMIT)) begin
            state_d = S_DONE;
          end else if (addr_bad) begin
            state_d = S_FAULT;
            fault_d = 2'b10;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (wd_expired) begin
          state_d = S_FAULT;
          fault_d = 2'b01;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      fault_q    <= 2'b00;
      in_valid_q <= 1'b0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      in_valid_q <= in_valid_d;
      inst_q     <= inst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && ctrl_open) begin
      mem[load_addr] <= load_data;
    end
  end

  assign in_valid   = in_valid_q;
  assign inst       = inst_q;
  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done       = (state_q == S_DONE);
  assign fault      = fault_q;
  assign issued_cnt = cnt_q;

endmodule

// File: doc/sp_inst_fetch.md
# sp_inst_fetch

Instruction fetch and issue stage that sits directly upstream of the single-cycle processor (SP) core. It holds program memory and issues one instruction at a time on the SP's `in_valid`/`inst` pair. It consumes the SP's `out_valid`/`inst_addr` completion report to choose the next instruction. A watchdog, an instruction-count limit and address checking end a run cleanly.

## Interface
Parameters:
- `DEPTH`, 1024: program memory size in 32-bit words; `load_addr` width is clog2(DEPTH).
- `INST_LIMIT`, 1000: number of instructions issued before the run completes.
- `MAX_LATENCY`, 10: maximum WAIT cycles allowed before `out_valid` must arrive.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `load_en`, in, 1: program memory write strobe; honoured only in IDLE, DONE or FAULT.
- `load_addr`, in, clog2(DEPTH): word address for the write.
- `load_data`, in, 32: instruction word to write.
- `start`, in, 1: begin a run at address 0; honoured in IDLE, DONE or FAULT.
- `out_valid`, in, 1: SP completion pulse.
- `inst_addr`, in, 32: SP next-PC byte address, valid while `out_valid`=1.
- `in_valid`, out, 1: instruction valid to SP, one-cycle pulse.
- `inst`, out, 32: instruction to SP; 0 whenever `in_valid`=0.
- `busy`, out, 1: high in ISSUE and WAIT.
- `done`, out, 1: high in DONE, sticky.
- `fault`, out, 2: in FAULT, 01 = timeout, 10 = bad address; 00 otherwise.
- `issued_cnt`, out, 16: instructions issued in the current run.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, FAULT. Reset sends the FSM to IDLE.
- Reset values: `in_valid`=0, `inst`=0, `busy`=0, `done`=0, `fault`=00, `issued_cnt`=0, PC=0, watchdog=0.
- Program memory contents are not reset.
- IDLE/DONE/FAULT:
  - `load_en` writes `load_data` to `mem[load_addr]`.
  - `start` clears PC, `issued_cnt`, `done` and `fault`, then goes to ISSUE.
  - If `start` and `load_en` are high in the same cycle, the write completes first; the new word is visible to the first issue.
- ISSUE (one cycle):
  - `in_valid`=1 and `inst`=`mem[PC[11:2]]`, both registered on entry.
  - `issued_cnt` increments.
  - Next state is WAIT.
- WAIT:
  - Watchdog clears on entry and increments each cycle without `out_valid`.
  - On `out_valid`=1, PC is loaded with `inst_addr`. Then the first matching rule applies:
    - `issued_cnt`==INST_LIMIT → DONE.
    - `inst_addr[1:0]`≠0, or `inst_addr>>2` ≥ DEPTH → FAULT with code 10.
    - Otherwise → ISSUE.
  - If the watchdog reaches MAX_LATENCY−1 with no `out_valid` in that cycle → FAULT with code 01. `out_valid` in that same cycle has priority over the timeout.
- `out_valid` in IDLE, ISSUE, DONE or FAULT is ignored; PC is unchanged.
- `load_en` in ISSUE or WAIT is ignored; memory is unchanged.
- `start` in ISSUE or WAIT is ignored.
- `issued_cnt` saturates at 16'hFFFF.

## Timing
- `start` sampled at edge k → `in_valid`/`inst` high for the cycle after edge k+1.
- `out_valid` sampled at edge n → the next `in_valid` is high for the cycle after edge n+1. This gives exactly one idle cycle between completion and the next issue.
- A WAIT phase lasts at most MAX_LATENCY cycles.
- `done` and `fault` rise at the edge that leaves WAIT and stay high until `start` or reset.
- Reset asserted mid-run drops `in_valid` and `busy` immediately and asynchronously. No partial instruction is reissued after reset release.

## Configuration
- `SP_IF_WATCHDOG_EN` defined:
  - Watchdog counter and the timeout transition are present.
  - `fault` code 01 is reachable.
- `SP_IF_WATCHDOG_EN` undefined:
  - No watchdog logic; WAIT holds indefinitely until `out_valid`.
  - `fault` code 01 never occurs. `MAX_LATENCY` is accepted but unused.

## Test plan
- Reset check: pulse `rst_n` low with `clk` held → all outputs 0, FSM in IDLE, `in_valid`=0 for 5 cycles after release.
- Sequential run:
  - Setup: load `mem[0..3]`=32'h11,32'h22,32'h33,32'h44, `start`.
  - SP stub answers `out_valid` 2 cycles after each `in_valid`, with `inst_addr`=4,8,12,16.
  - Required: `inst` sequence 11,22,33,44; `issued_cnt`=4; exactly one idle cycle between each `out_valid` and the next `in_valid`.
- Jump/limit:
  - Setup: INST_LIMIT=3; stub returns `inst_addr`=12, 0, 12.
  - Required: `inst` = mem[0], mem[3], mem[0]; then `done`=1, `busy`=0; no 4th `in_valid`.
- Bad address: stub returns `inst_addr`=32'h6 → `fault`=10 the cycle after; no further `in_valid`; `start` then reissues mem[0].
- Watchdog (`SP_IF_WATCHDOG_EN` defined, MAX_LATENCY=10):
  - Stub never asserts `out_valid` → `fault`=01 after 10 WAIT cycles.
  - Repeat with `out_valid` in the 10th WAIT cycle → accepted, no fault.
- Ignored inputs:
  - `load_en` during WAIT → memory unchanged on readback after the run.
  - Reset mid-WAIT → `in_valid`=0 immediately; FSM in IDLE; `issued_cnt`=0.
